// File: rtl/xge_stats_cntr_if.sv
// xge_stats_cntr_if: 64-bit AXI4-Stream beat signals snooped by the statistics block.
interface xge_stats_cntr_if;
    logic       tvalid;
    logic       tready;
    logic [7:0] tkeep;
    logic       tlast;
    logic       tuser;
    modport master (output tvalid, tready, tkeep, tlast, tuser);
    modport slave  (input  tvalid, tready, tkeep, tlast, tuser);
endinterface

// File: rtl/xge_stats_cntr.sv
// xge_stats_cntr: saturating frame/byte statistics snooped from a 64-bit AXI4-Stream.
// Counters only change on registered edges so a slow-domain snapshot stays coherent.
module xge_stats_cntr #(
    parameter int CW      = 32,
    parameter int BW      = 48,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic                   clk,
    input  logic                   rst_n,
    xge_stats_cntr_if.slave        s_axis,
    input  logic                   clear,
    output logic [CW-1:0]          good_frames,
    output logic [CW-1:0]          bad_frames,
    output logic [CW-1:0]          runt_frames,
    output logic [CW-1:0]          over_frames,
    output logic [BW-1:0]          good_bytes
);
    localparam int SW = (BW > 16 ? BW : 16) + 1;
    typedef enum logic {S_IDLE, S_FRAME} state_t;
    state_t        state_q;
    logic [15:0]   len_acc_q, s1_len_q, len_d;
    logic          err_q, err_d, s1_vld_q, s1_user_q, s1_err_q;
    logic          beat, contig, beat_err, runt, over, good;
    logic [16:0]   len_sum;
    logic [SW-1:0] byte_sum;
    logic [CW-1:0] good_frames_q, bad_frames_q, runt_frames_q, over_frames_q;
    logic [CW-1:0] good_frames_d, bad_frames_d, runt_frames_d, over_frames_d;
    logic [BW-1:0] good_bytes_q, good_bytes_d;
    always_comb begin
        beat          = s_axis.tvalid & s_axis.tready;
        len_sum       = {1'b0, (state_q == S_FRAME ? len_acc_q : 16'd0)} + 17'($countones(s_axis.tkeep));
        len_d         = len_sum[16] ? 16'hFFFF : len_sum[15:0];
        // Contiguous-from-bit-0 masks are exactly those where keep & (keep+1) == 0
        contig        = ~|({1'b0, s_axis.tkeep} & ({1'b0, s_axis.tkeep} + 9'd1));
        beat_err      = ~|s_axis.tkeep | (s_axis.tlast ? ~contig : s_axis.tkeep != 8'hFF);
        err_d         = (state_q == S_FRAME & err_q) | beat_err;
        runt          = int'(s1_len_q) < MIN_LEN;
        over          = int'(s1_len_q) > MAX_LEN;
        good          = s1_user_q & ~s1_err_q & ~runt & ~over;
        byte_sum      = SW'(good_bytes_q) + SW'(s1_len_q);
        good_frames_d = s1_vld_q & good & ~&good_frames_q ? good_frames_q + CW'(1) : good_frames_q;
        bad_frames_d  = s1_vld_q & ~good & ~&bad_frames_q ? bad_frames_q + CW'(1) : bad_frames_q;
        runt_frames_d = s1_vld_q & runt & ~&runt_frames_q ? runt_frames_q + CW'(1) : runt_frames_q;
        over_frames_d = s1_vld_q & over & ~&over_frames_q ? over_frames_q + CW'(1) : over_frames_q;
        good_bytes_d  = ~(s1_vld_q & good) ? good_bytes_q : (|byte_sum[SW-1:BW] ? '1 : byte_sum[BW-1:0]);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            len_acc_q     <= '0;
            err_q         <= 1'b0;
            s1_vld_q      <= 1'b0;
            s1_len_q      <= '0;
            s1_user_q     <= 1'b0;
            s1_err_q      <= 1'b0;
            good_frames_q <= '0;
            bad_frames_q  <= '0;
            runt_frames_q <= '0;
            over_frames_q <= '0;
            good_bytes_q  <= '0;
        end else begin
            s1_vld_q <= beat & s_axis.tlast;
            if (beat) begin
                state_q   <= s_axis.tlast ? S_IDLE : S_FRAME;
                len_acc_q <= s_axis.tlast ? 16'd0 : len_d;
                err_q     <= ~s_axis.tlast & err_d;
            end
            if (beat & s_axis.tlast) begin
                s1_len_q  <= len_d;
                s1_user_q <= s_axis.tuser;
                s1_err_q  <= err_d;
            end
            good_frames_q <= clear ? '0 : good_frames_d;
            bad_frames_q  <= clear ? '0 : bad_frames_d;
            runt_frames_q <= clear ? '0 : runt_frames_d;
            over_frames_q <= clear ? '0 : over_frames_d;
            good_bytes_q  <= clear ? '0 : good_bytes_d;
        end
    end
    assign good_frames = good_frames_q;
    assign bad_frames  = bad_frames_q;
    assign runt_frames = runt_frames_q;
    assign over_frames = over_frames_q;
    assign good_bytes  = good_bytes_q;
endmodule

// File: tb/tb_xge_stats_cntr.sv
// tb_xge_stats_cntr: randomized + directed bench; a full-size and a tiny (fast-saturating)
// instance share one stream and are checked every cycle against a frame-level model.
module tb_xge_stats_cntr;
    logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
    always #5 clk = ~clk;
    xge_stats_cntr_if axis ();
    logic [31:0] gf0, bf0, rf0, of0;
    logic [47:0] gb0;
    logic [2:0]  gf1, bf1, rf1, of1;
    logic [7:0]  gb1;
    xge_stats_cntr dut0 (
        .clk(clk), .rst_n(rst_n), .s_axis(axis.slave), .clear(clear),
        .good_frames(gf0), .bad_frames(bf0), .runt_frames(rf0), .over_frames(of0), .good_bytes(gb0)
    );
    xge_stats_cntr #(.CW(3), .BW(8), .MIN_LEN(8), .MAX_LEN(40)) dut1 (
        .clk(clk), .rst_n(rst_n), .s_axis(axis.slave), .clear(clear),
        .good_frames(gf1), .bad_frames(bf1), .runt_frames(rf1), .over_frames(of1), .good_bytes(gb1)
    );
    // Model state: expected counters [inst][good,bad,runt,over,bytes]
    longint exp_c [2][5];
    int     cw_p [2] = '{32, 3};
    int     bw_p [2] = '{48, 8};
    int     mn_p [2] = '{64, 8};
    int     mx_p [2] = '{1518, 40};
    bit     pend, pend_user, pend_err, f_err;
    int     pend_len, f_len;
    int     checks = 0, errors = 0;
    int     gap_pct = 0, clr_en = 0, rst_en = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic longint sat_add(input longint v, input longint a, input int w);
        longint lim = (longint'(1) << w) - 1;
        return (v + a > lim) ? lim : v + a;
    endfunction
    function automatic bit keep_ok(input logic [7:0] k, input bit last);
        if (k == 8'h00) return 1'b0;
        if (!last) return k == 8'hFF;
        for (int n = 1; n <= 8; n++) if (int'(k) == (1 << n) - 1) return 1'b1;
        return 1'b0;
    endfunction
    task automatic account(input int len, input bit user, input bit err);
        for (int i = 0; i < 2; i++) begin
            bit runt = len < mn_p[i];
            bit over = len > mx_p[i];
            if (user && !err && !runt && !over) begin
                exp_c[i][0] = sat_add(exp_c[i][0], 1, cw_p[i]);
                exp_c[i][4] = sat_add(exp_c[i][4], len, bw_p[i]);
            end else begin
                exp_c[i][1] = sat_add(exp_c[i][1], 1, cw_p[i]);
                if (runt) exp_c[i][2] = sat_add(exp_c[i][2], 1, cw_p[i]);
                if (over) exp_c[i][3] = sat_add(exp_c[i][3], 1, cw_p[i]);
            end
        end
    endtask
    task automatic cyc(input bit v, input bit r, input logic [7:0] k, input bit l, input bit u,
                       input bit clr, input bit rn);
        @(negedge clk);
        axis.tvalid = v; axis.tready = r; axis.tkeep = k; axis.tlast = l; axis.tuser = u;
        clear = clr; rst_n = rn;
        @(posedge clk);
        #1;
        if (!rn) begin
            foreach (exp_c[i, j]) exp_c[i][j] = 0;
            pend = 0; f_len = 0; f_err = 0;
        end else begin
            if (clr) foreach (exp_c[i, j]) exp_c[i][j] = 0;
            else if (pend) account(pend_len, pend_user, pend_err);
            pend = 0;
            if (v && r) begin
                f_len += $countones(k);
                f_err |= !keep_ok(k, l);
                if (l) begin
                    pend = 1; pend_len = f_len > 65535 ? 65535 : f_len; pend_user = u; pend_err = f_err;
                    f_len = 0; f_err = 0;
                end
            end
        end
        check("good_frames0", 64'(gf0), exp_c[0][0]);
        check("bad_frames0",  64'(bf0), exp_c[0][1]);
        check("runt_frames0", 64'(rf0), exp_c[0][2]);
        check("over_frames0", 64'(of0), exp_c[0][3]);
        check("good_bytes0",  64'(gb0), exp_c[0][4]);
        check("good_frames1", 64'(gf1), exp_c[1][0]);
        check("bad_frames1",  64'(bf1), exp_c[1][1]);
        check("runt_frames1", 64'(rf1), exp_c[1][2]);
        check("over_frames1", 64'(of1), exp_c[1][3]);
        check("good_bytes1",  64'(gb1), exp_c[1][4]);
    endtask
    task automatic idle(input int n);
        repeat (n) cyc(0, 1, 8'h00, 0, 0, 0, 1);
    endtask
    // Non-beat cycles carry junk sideband, plus the odd clear or reset when enabled
    task automatic gaps();
        while ($urandom_range(0, 99) < gap_pct) begin
            bit v = $urandom_range(0, 1) == 1;
            bit r = v ? 1'b0 : ($urandom_range(0, 1) == 1);
            bit c = clr_en != 0 && $urandom_range(0, 39) == 0;
            bit n = !(rst_en != 0 && $urandom_range(0, 299) == 0);
            cyc(v, r, 8'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, c, n);
        end
    endtask
    task automatic send(input int len, input bit u, input int bad_mid, input bit bad_last);
        int nb = (len + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            logic [7:0] k;
            bit last = b == nb - 1;
            int rem = len - 8 * b;
            k = rem >= 8 ? 8'hFF : 8'((1 << rem) - 1);
            if (!last && b == bad_mid) k = 8'h7F;
            if (last && bad_last) k = 8'h05;
            gaps();
            cyc(1, 1, k, last, last ? u : ($urandom_range(0, 1) == 1), 0, 1);
        end
    endtask
    initial begin
        axis.tvalid = 0; axis.tready = 0; axis.tkeep = 0; axis.tlast = 0; axis.tuser = 0;
        foreach (exp_c[i, j]) exp_c[i][j] = 0;
        pend = 0; f_len = 0; f_err = 0;
        repeat (2) cyc(0, 0, 8'h00, 0, 0, 0, 0);
        idle(1);
        send(64, 1, -1, 0);   idle(2);
        send(60, 1, -1, 0);   idle(2);
        send(1519, 1, -1, 0); idle(2);
        send(1518, 1, -1, 0); idle(2);
        send(128, 1, 5, 0);   idle(2);
        send(64, 1, -1, 1);   idle(2);
        send(64, 0, -1, 0);   idle(2);
        gap_pct = 40;
        send(200, 1, -1, 0);  idle(2);
        gap_pct = 0;
        send(64, 1, -1, 0);
        cyc(0, 1, 8'h00, 0, 0, 1, 1);
        idle(1);
        send(64, 1, -1, 0);   idle(2);
        repeat (20) cyc(1, 1, 8'hFF, 1, 1, 0, 1);
        repeat (10) send(32, 1, -1, 0);
        idle(2);
        send(40, 1, -1, 0);
        cyc(1, 1, 8'h00, 1, 1, 0, 1);
        idle(2);
        repeat (3) cyc(1, 1, 8'hFF, 0, 0, 0, 1);
        cyc(0, 0, 8'h00, 0, 0, 0, 0);
        send(24, 1, -1, 0);   idle(2);
        repeat (3) cyc(1, 1, 8'hFF, 0, 0, 0, 1);
        cyc(0, 1, 8'h00, 0, 0, 1, 1);
        send(24, 1, -1, 0);   idle(2);
        gap_pct = 20; clr_en = 1; rst_en = 1;
        repeat (150) begin
            int sel, len;
            sel = $urandom_range(0, 9);
            len = sel < 5 ? $urandom_range(1, 100) : sel < 9 ? $urandom_range(1, 300) : $urandom_range(1400, 1600);
            send(len, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0 ? $urandom_range(0, len / 8) : -1,
                 $urandom_range(0, 19) == 0);
        end
        gap_pct = 0;
        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
